power_logger_array: RTL

Multi-channel successor to the single converter/collector pair. CHANNELS independent converter channels, each with a selectable mode (off/bypass/scaled), saturating Q2.2 gain and a slew-rate-limited output. A decimating scan FSM snapshots all channel outputs and queues channel-tagged samples into a first-word-fall-through (FWFT) FIFO. The FIFO is drained through a valid/ready interface. The block sits between the analog front-end sample bus and the telemetry/readout logic.

---
 rtl/power_logger_pkg.sv | 25 ++
 rtl/slew_converter_ch.sv | 79 +++++++
 rtl/power_logger_array.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/power_logger_pkg.sv
// Shared encodings, constants and helpers for the multi-channel power logger.
package power_logger_pkg;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_BYPASS = 2'b01;
    localparam logic [1:0] MODE_SCALED = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    localparam int RATIO_FRAC_BITS = 2;
    localparam int DROP_W          = 8;

    // Drop counter sticks at full scale instead of wrapping.
    function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] cnt);
        if (cnt == {DROP_W{1'b1}}) begin
            return cnt;
        end else begin
            return cnt + DROP_W'(1);
        end
    endfunction

endpackage

// File: rtl/slew_converter_ch.sv
// One converter channel: mode-selected target (with saturating Q2.2 gain)
// followed by a slew-rate-limited output register.
module slew_converter_ch
    import power_logger_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] vin,
    input  logic [1:0]       mode,
    input  logic [3:0]       ratio,
    output logic [WIDTH-1:0] vout
);

    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
    localparam logic [WIDTH+3:0] SAT_V  = {4'b0000, {WIDTH{1'b1}}};

    logic [WIDTH+3:0] product_s;
    logic [WIDTH+3:0] shifted_s;
    logic [WIDTH-1:0] scaled_s;
    logic [WIDTH-1:0] target_s;
    logic [WIDTH-1:0] delta_s;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] vout_r;

    // Gain stage: full-precision product, drop the two fraction bits, clamp to full scale.
    always_comb begin
        product_s = {4'b0000, vin} * {{WIDTH{1'b0}}, ratio};
        shifted_s = product_s >> RATIO_FRAC_BITS;
        if (shifted_s > SAT_V) begin
            scaled_s = {WIDTH{1'b1}};
        end else begin
            scaled_s = shifted_s[WIDTH-1:0];
        end
    end

    // Target selection; the unused encoding behaves like off.
    always_comb begin
        case (mode)
            MODE_BYPASS: target_s = vin;
            MODE_SCALED: target_s = scaled_s;
            MODE_OFF:    target_s = {WIDTH{1'b0}};
            default:     target_s = {WIDTH{1'b0}};
        endcase
    end

    // Move toward the target by at most STEP per cycle.
    always_comb begin
        if (target_s >= vout_r) begin
            delta_s = target_s - vout_r;
            if (delta_s <= STEP_V) begin
                next_s = target_s;
            end else begin
                next_s = vout_r + STEP_V;
            end
        end else begin
            delta_s = vout_r - target_s;
            if (delta_s <= STEP_V) begin
                next_s = target_s;
            end else begin
                next_s = vout_r - STEP_V;
            end
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vout_r <= {WIDTH{1'b0}};
        end else begin
            vout_r <= next_s;
        end
    end

    assign vout = vout_r;

endmodule

// File: rtl/power_logger_array.sv
// Multi-channel power logger: slew-limited converters, a decimated scan that
// snapshots every channel, and a channel-tagged FWFT FIFO drained by valid/ready.
module power_logger_array
    import power_logger_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int DEPTH    = 16,
    parameter  int STEP     = 8,
    parameter  int DECIM_W  = 8,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] vin,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [3:0]                ratio,
    input  logic                      log_en,
    input  logic [DECIM_W-1:0]        decim,
    output logic [CHANNELS*WIDTH-1:0] vout,
    output logic [WIDTH-1:0]          data_out,
    output logic [CH_W-1:0]           data_ch,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic                      overflow,
    input  logic                      clear_ovf,
    output logic [DROP_W-1:0]         drop_count,
    output logic                      busy
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              ENTRY_W  = CH_W + WIDTH;
    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(CHANNELS - 1);

    logic [DECIM_W-1:0] decim_cnt_r;
    logic               tick_s;
    scan_state_t        state_r;
    scan_state_t        state_next_s;
    logic [CH_W-1:0]    idx_r;
    logic [CH_W-1:0]    idx_next_s;
    logic               snap_load_s;
    logic [WIDTH-1:0]   snap_r [CHANNELS];
    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [AW:0]        wr_ptr_r;
    logic [AW:0]        rd_ptr_r;
    logic               empty_s;
    logic               full_s;
    logic               push_s;
    logic               pop_s;
    logic               push_ok_s;
    logic               drop_s;
    logic [ENTRY_W-1:0] push_entry_s;
    logic [ENTRY_W-1:0] head_s;
    logic               overflow_r;
    logic [DROP_W-1:0]  drop_cnt_r;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        slew_converter_ch #(
            .WIDTH (WIDTH),
            .STEP  (STEP)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .vin   (vin[g*WIDTH +: WIDTH]),
            .mode  (mode[2*g +: 2]),
            .ratio (ratio),
            .vout  (vout[g*WIDTH +: WIDTH])
        );
    end

    assign tick_s = log_en && (decim_cnt_r == decim);

    // Decimation counter; parked at zero while logging is disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            decim_cnt_r <= {DECIM_W{1'b0}};
        end else if (!log_en || tick_s) begin
            decim_cnt_r <= {DECIM_W{1'b0}};
        end else begin
            decim_cnt_r <= decim_cnt_r + DECIM_W'(1);
        end
    end

    // Scan FSM next-state: ticks are only honoured from IDLE.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        snap_load_s  = 1'b0;
        push_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (tick_s) begin
                    state_next_s = SCAN;
                    idx_next_s   = {CH_W{1'b0}};
                    snap_load_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SCAN: begin
                push_s = 1'b1;
                if (idx_r == LAST_IDX) begin
                    state_next_s = IDLE;
                    idx_next_s   = {CH_W{1'b0}};
                end else begin
                    idx_next_s = idx_r + CH_W'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
                idx_next_s   = {CH_W{1'b0}};
            end
        endcase
    end

    // Scan state, index and channel snapshot registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            idx_r   <= {CH_W{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                snap_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            if (snap_load_s) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    snap_r[i] <= vout[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign busy         = (state_r == SCAN);
    assign push_entry_s = {idx_r, snap_r[idx_r]};

    // The extra pointer bit tells full from empty when the index bits match.
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s     = !empty_s && data_ready;
    assign push_ok_s = push_s && (!full_s || pop_s);
    assign drop_s    = push_s && !push_ok_s;
    assign head_s    = mem_r[rd_ptr_r[AW-1:0]];

    assign data_valid = !empty_s;
    assign data_out   = empty_s ? {WIDTH{1'b0}} : head_s[WIDTH-1:0];
    assign data_ch    = empty_s ? {CH_W{1'b0}}  : head_s[ENTRY_W-1 -: CH_W];

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_entry_s;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Overflow tracking; a drop in the same cycle as a clear still registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_W{1'b0}};
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            drop_cnt_r <= clear_ovf ? DROP_W'(1) : sat_inc_drop(drop_cnt_r);
        end else if (clear_ovf) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_W{1'b0}};
        end
    end

    assign overflow   = overflow_r;
    assign drop_count = drop_cnt_r;

endmodule
